mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control sequencer for the MIPS datapath (npc/pc/im, RegFile, alu, ext, Datamemory and the three 2:1 muxes). It replaces the single-cycle combinational `controller` with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It gates PC, IR, register-file and memory writes to the correct cycle, and it counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `Clk` in 1: the single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26], valid from the ID state onward.
- `funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag.
- `DMReady` in 1: data-memory ready. Present only when `MC_MEM_WAIT_EN` is defined.
- `PCWr` out 1: PC load enable.
- `IRWr` out 1: instruction register load enable.
- `nPC_sel` out 2: next-PC source. 00 = PC+4, 01 = branch target, 10 = jump target.
- `RegWr` out 1: register-file write enable.
- `RegDst` out 1: write-register select. 0 = rt, 1 = rd.
- `ExtOp` out 1: immediate extension. 0 = zero-extend, 1 = sign-extend.
- `ALUSrc` out 1: ALU B input. 0 = BusB, 1 = imm32.
- `MemWr` out 1: data-memory write enable.
- `MemtoReg` out 1: write-back source. 0 = ALU, 1 = DM.
- `ALUctr` out 3: ALU operation. 000 add, 001 sub, 010 or, 011 slt.
- `State` out 3: current state, for debug.
- `Illegal` out 1: one-cycle pulse when an unsupported instruction is decoded.
- `InstrCnt` out CNT_W: count of retired instructions.

## Operation
Supported instructions:
- R-type (op 000000) with funct 100001 addu, 100011 subu, 101010 slt.
- ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
- Every other op/funct combination is illegal.

Register behaviour:
- In ID, `opcode` and `funct` are latched into an internal op register.
- All outputs in EX, MEM and WB decode from this latched copy, not from the live inputs.

States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, WAIT=5 (WAIT exists only with the macro).

Per-state behaviour (any output not listed is 0):
- **IF**
  - Asserts `IRWr=1`, `PCWr=1`, `nPC_sel=00`.
  - Always goes to ID.
- **ID**, by decoded instruction:
  - j: asserts `PCWr=1`, `nPC_sel=10`; retires; goes to IF.
  - Illegal instruction: asserts `Illegal=1`; does not retire; goes to IF.
  - Anything else: goes to EX.
- **EX**, by decoded instruction:
  - R-type: `RegDst=1`, `ALUSrc=0`, `ALUctr` from funct; goes to WB.
  - ori: `ALUSrc=1`, `ExtOp=0`, `ALUctr=010`; goes to WB.
  - lw/sw: `ALUSrc=1`, `ExtOp=1`, `ALUctr=000`; goes to MEM.
  - beq: `ALUctr=001`, `ALUSrc=0`, `ExtOp=1`, `nPC_sel=01`, `PCWr=Zero`; retires; goes to IF.
- **MEM**: holds the EX-state ALU controls.
  - sw: `MemWr=1`; retires; goes to IF.
  - lw: goes to WB.
- **WB**: `RegWr=1`, and holds the ALU/mux controls for the instruction.
  - lw: `MemtoReg=1`, `RegDst=0`.
  - ori: `RegDst=0`.
  - Retires; goes to IF.

Counter:
- `InstrCnt` increments by 1 on the clock edge that leaves a retiring state.
- Wraps from all-ones to 0 with no flag.

Reset:
- While `Reset` is high on an edge, the next state is IF, `InstrCnt` is 0 and the op register is 0.
- Reset asserted mid-instruction abandons that instruction without a write: `RegWr`, `MemWr` and `PCWr` are forced to 0 during any cycle in which `Reset` is high.

## Timing
- Outputs are a Moore decode of state plus the latched op; there is no combinational path from `opcode`/`funct` to outputs outside ID.
- `PCWr` in EX depends combinationally on `Zero`.
- Cycles per instruction, IF through retirement: j 2, beq 3, sw 4, R/ori 4, lw 5.
- Reset values: state IF, `InstrCnt` 0, `Illegal` 0. Write enables are 0 while `Reset` is high; the first cycle after release is IF with `IRWr=PCWr=1`.
- `Illegal` is high for exactly the one ID cycle; the PC has already advanced past the illegal word.
- The first instruction that retires makes `InstrCnt` 1 on the following cycle.

## Configuration
- `MC_MEM_WAIT_EN` defined:
  - The `DMReady` port exists.
  - For lw/sw, MEM goes to WAIT when `DMReady=0`. The MEM-state outputs (including `MemWr` for sw) are held in WAIT until a cycle with `DMReady=1`, then the FSM proceeds as it would from MEM.
  - If `DMReady=1` in MEM, there is no WAIT cycle.
- `MC_MEM_WAIT_EN` undefined:
  - No `DMReady` port and no WAIT state; MEM is always exactly one cycle.
  - State value 5 is unreachable; if it is ever entered, the next state is IF.

## Test plan
- **Reset:** hold `Reset` 3 cycles, release. Required: `State` is 0 with `PCWr=IRWr=1` in the first cycle, `InstrCnt=0`, and no `RegWr`/`MemWr` during reset.
- **Instruction sequence:** addu, ori, lw, sw, j. Required: state traces 0-1-2-4, 0-1-2-4, 0-1-2-3-4, 0-1-2-3, 0-1; `InstrCnt=5` after 19 cycles; `MemtoReg=1` only in lw's WB.
- **beq:** with `Zero=1`, `PCWr=1` and `nPC_sel=01` in EX. With `Zero=0`, `PCWr=0`. Both take 3 cycles and both increment the counter.
- **Illegal instruction:** op 111111. Required: `Illegal` pulses for one cycle in ID, back to IF next cycle, `InstrCnt` unchanged, no write enables.
- **Reset mid-instruction:** assert `Reset` during lw MEM. Required: next state IF, no `RegWr`, `InstrCnt=0`.
- **Memory wait (`MC_MEM_WAIT_EN` only):** sw with `DMReady` low for 3 cycles. Required: `MemWr` held through MEM plus 3 WAIT cycles, retires on the cycle `DMReady=1`, sw takes 7 cycles total.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: IF/ID/EX/MEM/WB Moore FSM with retired-instruction counter.
// Optional MC_MEM_WAIT_EN adds a DMReady input and a WAIT state for slow data memory.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             Zero,
`ifdef MC_MEM_WAIT_EN
   input  logic             DMReady,
`endif
   output logic             PCWr,
   output logic             IRWr,
   output logic [1:0]       nPC_sel,
   output logic             RegWr,
   output logic             RegDst,
   output logic             ExtOp,
   output logic             ALUSrc,
   output logic             MemWr,
   output logic             MemtoReg,
   output logic [2:0]       ALUctr,
   output logic [2:0]       State,
   output logic             Illegal,
   output logic [CNT_W-1:0] InstrCnt
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_WAIT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      I_ADDU, I_SUBU, I_SLT, I_ORI, I_LW, I_SW, I_BEQ, I_J, I_ILL
   } ins_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [5:0]       fn_q, fn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   ins_t       ins;
   logic       mem_ready;
   logic       retire;
   logic       pc_wr, reg_wr, mem_wr;

   function automatic ins_t decode(input logic [5:0] op, input logic [5:0] fn);
      ins_t r;
      r = I_ILL;
      case (op)
         6'b000000: begin
            case (fn)
               6'b100001: r = I_ADDU;
               6'b100011: r = I_SUBU;
               6'b101010: r = I_SLT;
               default:   r = I_ILL;
            endcase
         end
         6'b001101: r = I_ORI;
         6'b100011: r = I_LW;
         6'b101011: r = I_SW;
         6'b000100: r = I_BEQ;
         6'b000010: r = I_J;
         default:   r = I_ILL;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] r_aluctr(input ins_t i);
      logic [2:0] a;
      case (i)
         I_SUBU:  a = ALU_SUB;
         I_SLT:   a = ALU_SLT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // The live IR is only trusted in ID; later states decode the latched copy.
   always_comb begin
      ins = (state_q == S_ID) ? decode(opcode, funct) : decode(op_q, fn_q);
   end

`ifdef MC_MEM_WAIT_EN
   always_comb mem_ready = DMReady;
`else
   always_comb mem_ready = 1'b1;
`endif

   always_comb begin
      state_d  = S_IF;
      op_d     = op_q;
      fn_d     = fn_q;
      retire   = 1'b0;
      pc_wr    = 1'b0;
      reg_wr   = 1'b0;
      mem_wr   = 1'b0;
      IRWr     = 1'b0;
      nPC_sel  = 2'b00;
      RegDst   = 1'b0;
      ExtOp    = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      ALUctr   = ALU_ADD;
      Illegal  = 1'b0;
      case (state_q)
         S_IF: begin
            IRWr    = 1'b1;
            pc_wr   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            op_d = opcode;
            fn_d = funct;
            case (ins)
               I_J: begin
                  pc_wr   = 1'b1;
                  nPC_sel = 2'b10;
                  retire  = 1'b1;
               end
               I_ILL:   Illegal = 1'b1;
               default: state_d = S_EX;
            endcase
         end
         S_EX: begin
            case (ins)
               I_ADDU, I_SUBU, I_SLT: begin
                  RegDst  = 1'b1;
                  ALUctr  = r_aluctr(ins);
                  state_d = S_WB;
               end
               I_ORI: begin
                  ALUSrc  = 1'b1;
                  ALUctr  = ALU_OR;
                  state_d = S_WB;
               end
               I_LW, I_SW: begin
                  ExtOp   = 1'b1;
                  ALUSrc  = 1'b1;
                  state_d = S_MEM;
               end
               I_BEQ: begin
                  ExtOp   = 1'b1;
                  ALUctr  = ALU_SUB;
                  nPC_sel = 2'b01;
                  pc_wr   = Zero;
                  retire  = 1'b1;
               end
               default: state_d = S_IF;
            endcase
         end
`ifdef MC_MEM_WAIT_EN
         S_MEM, S_WAIT: begin
`else
         S_MEM: begin
`endif
            ExtOp  = 1'b1;
            ALUSrc = 1'b1;
            mem_wr = (ins == I_SW);
            if (!mem_ready) begin
               state_d = S_WAIT;
            end else if (ins == I_SW) begin
               retire  = 1'b1;
            end else if (ins == I_LW) begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            case (ins)
               I_ADDU, I_SUBU, I_SLT: begin
                  reg_wr = 1'b1;
                  RegDst = 1'b1;
                  ALUctr = r_aluctr(ins);
                  retire = 1'b1;
               end
               I_ORI: begin
                  reg_wr = 1'b1;
                  ALUSrc = 1'b1;
                  ALUctr = ALU_OR;
                  retire = 1'b1;
               end
               I_LW: begin
                  reg_wr   = 1'b1;
                  MemtoReg = 1'b1;
                  ExtOp    = 1'b1;
                  ALUSrc   = 1'b1;
                  retire   = 1'b1;
               end
               default: ;
            endcase
         end
         default: state_d = S_IF;
      endcase
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // Reset abandons the instruction in flight: no architectural write may land.
   always_comb begin
      PCWr  = pc_wr  && !Reset;
      RegWr = reg_wr && !Reset;
      MemWr = mem_wr && !Reset;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IF;
         op_q    <= '0;
         fn_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fn_q    <= fn_d;
         cnt_q   <= cnt_d;
      end
   end

   assign State    = state_q;
   assign InstrCnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl; a 2-bit-counter copy checks counter wrap.
module tb_mc_ctrl;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BAD = 6'b111111;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_ADD  = 6'b100000;

   // ctl = {PCWr, IRWr, nPC_sel, RegWr, RegDst, ExtOp, ALUSrc, MemWr, MemtoReg, ALUctr, Illegal}
   localparam logic [13:0] C_NONE    = 14'b00000000000000;
   localparam logic [13:0] C_IF      = 14'b11000000000000;
   localparam logic [13:0] C_RST     = 14'b01000000000000;
   localparam logic [13:0] C_J       = 14'b10100000000000;
   localparam logic [13:0] C_ILL     = 14'b00000000000001;
   localparam logic [13:0] C_EX_ADD  = 14'b00000100000000;
   localparam logic [13:0] C_WB_ADD  = 14'b00001100000000;
   localparam logic [13:0] C_EX_SUB  = 14'b00000100000010;
   localparam logic [13:0] C_WB_SUB  = 14'b00001100000010;
   localparam logic [13:0] C_EX_SLT  = 14'b00000100000110;
   localparam logic [13:0] C_WB_SLT  = 14'b00001100000110;
   localparam logic [13:0] C_EX_ORI  = 14'b00000001000100;
   localparam logic [13:0] C_WB_ORI  = 14'b00001001000100;
   localparam logic [13:0] C_EX_MEM  = 14'b00000011000000;
   localparam logic [13:0] C_MEM_SW  = 14'b00000011100000;
   localparam logic [13:0] C_WB_LW   = 14'b00001011010000;
   localparam logic [13:0] C_BEQ_T   = 14'b10010010000010;
   localparam logic [13:0] C_BEQ_N   = 14'b00010010000010;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        zero;
      logic        dmr;
      logic [2:0]  st;
      logic [13:0] ctl;
      int unsigned cnt;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        zero, dmready;
   logic        pc_wr, ir_wr, reg_wr, reg_dst, ext_op, alu_src, mem_wr, mem_to_reg, illegal;
   logic [1:0]  npc_sel;
   logic [2:0]  alu_ctr, state;
   logic [31:0] instr_cnt;
   logic        pc_wr2, ir_wr2, reg_wr2, reg_dst2, ext_op2, alu_src2, mem_wr2, mem_to_reg2, illegal2;
   logic [1:0]  npc_sel2;
   logic [2:0]  alu_ctr2, state2;
   logic [1:0]  instr_cnt2;

   vec_t tv[$];
   int   errors = 0;
   int   checks = 0;

   mc_ctrl #(.CNT_W(32)) u_dut (
      .Clk(clk), .Reset(rst), .opcode(opcode), .funct(funct), .Zero(zero),
`ifdef MC_MEM_WAIT_EN
      .DMReady(dmready),
`endif
      .PCWr(pc_wr), .IRWr(ir_wr), .nPC_sel(npc_sel), .RegWr(reg_wr), .RegDst(reg_dst),
      .ExtOp(ext_op), .ALUSrc(alu_src), .MemWr(mem_wr), .MemtoReg(mem_to_reg),
      .ALUctr(alu_ctr), .State(state), .Illegal(illegal), .InstrCnt(instr_cnt)
   );

   mc_ctrl #(.CNT_W(2)) u_dut_w2 (
      .Clk(clk), .Reset(rst), .opcode(opcode), .funct(funct), .Zero(zero),
`ifdef MC_MEM_WAIT_EN
      .DMReady(dmready),
`endif
      .PCWr(pc_wr2), .IRWr(ir_wr2), .nPC_sel(npc_sel2), .RegWr(reg_wr2), .RegDst(reg_dst2),
      .ExtOp(ext_op2), .ALUSrc(alu_src2), .MemWr(mem_wr2), .MemtoReg(mem_to_reg2),
      .ALUctr(alu_ctr2), .State(state2), .Illegal(illegal2), .InstrCnt(instr_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic [2:0] s, input logic [13:0] c, input int unsigned n,
                      input logic d = 1'b1);
      vec_t v;
      v.rst = r; v.op = o; v.fn = f; v.zero = z; v.dmr = d;
      v.st = s; v.ctl = c; v.cnt = n;
      tv.push_back(v);
   endtask

   task automatic check(input string name, input int row, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
      end
   endtask

   initial begin
      logic [13:0] ctl;
      rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; dmready = 1'b1;

      // Reset held three edges in total (one here, two table rows)
      add(1, OP_R, 6'd0, 0, 3'd0, C_RST, 0);
      add(1, OP_R, 6'd0, 0, 3'd0, C_RST, 0);
      // addu
      add(0, OP_R, F_ADDU, 0, 3'd0, C_IF,     0);
      add(0, OP_R, F_ADDU, 1, 3'd1, C_NONE,   0);
      add(0, OP_R, F_ADDU, 1, 3'd2, C_EX_ADD, 0);
      add(0, OP_R, F_ADDU, 0, 3'd4, C_WB_ADD, 0);
      // ori
      add(0, OP_ORI, 6'h15, 0, 3'd0, C_IF,     1);
      add(0, OP_ORI, 6'h15, 0, 3'd1, C_NONE,   1);
      add(0, OP_ORI, 6'h15, 0, 3'd2, C_EX_ORI, 1);
      add(0, OP_ORI, 6'h15, 0, 3'd4, C_WB_ORI, 1);
      // lw
      add(0, OP_LW, 6'h04, 0, 3'd0, C_IF,     2);
      add(0, OP_LW, 6'h04, 0, 3'd1, C_NONE,   2);
      add(0, OP_LW, 6'h04, 0, 3'd2, C_EX_MEM, 2);
      add(0, OP_LW, 6'h04, 0, 3'd3, C_EX_MEM, 2);
      add(0, OP_LW, 6'h04, 0, 3'd4, C_WB_LW,  2);
      // sw
      add(0, OP_SW, 6'h08, 0, 3'd0, C_IF,     3);
      add(0, OP_SW, 6'h08, 0, 3'd1, C_NONE,   3);
      add(0, OP_SW, 6'h08, 0, 3'd2, C_EX_MEM, 3);
      add(0, OP_SW, 6'h08, 0, 3'd3, C_MEM_SW, 3);
      // j
      add(0, OP_J, 6'h00, 0, 3'd0, C_IF, 4);
      add(0, OP_J, 6'h00, 0, 3'd1, C_J,  4);
      // beq taken, then not taken
      add(0, OP_BEQ, 6'h01, 1, 3'd0, C_IF,    5);
      add(0, OP_BEQ, 6'h01, 0, 3'd1, C_NONE,  5);
      add(0, OP_BEQ, 6'h01, 1, 3'd2, C_BEQ_T, 5);
      add(0, OP_BEQ, 6'h01, 0, 3'd0, C_IF,    6);
      add(0, OP_BEQ, 6'h01, 1, 3'd1, C_NONE,  6);
      add(0, OP_BEQ, 6'h01, 0, 3'd2, C_BEQ_N, 6);
      // slt, subu
      add(0, OP_R, F_SLT, 0, 3'd0, C_IF,     7);
      add(0, OP_R, F_SLT, 0, 3'd1, C_NONE,   7);
      add(0, OP_R, F_SLT, 0, 3'd2, C_EX_SLT, 7);
      add(0, OP_R, F_SLT, 0, 3'd4, C_WB_SLT, 7);
      add(0, OP_R, F_SUBU, 0, 3'd0, C_IF,     8);
      add(0, OP_R, F_SUBU, 0, 3'd1, C_NONE,   8);
      add(0, OP_R, F_SUBU, 0, 3'd2, C_EX_SUB, 8);
      add(0, OP_R, F_SUBU, 0, 3'd4, C_WB_SUB, 8);
      // illegal opcode, then illegal R-type funct: no retire, no writes
      add(0, OP_BAD, 6'h00, 0, 3'd0, C_IF,  9);
      add(0, OP_BAD, 6'h00, 0, 3'd1, C_ILL, 9);
      add(0, OP_R,   F_ADD, 0, 3'd0, C_IF,  9);
      add(0, OP_R,   F_ADD, 0, 3'd1, C_ILL, 9);
      // lw with IR garbage after ID (latched op must win), reset during MEM
      add(0, OP_LW,  6'h00, 0, 3'd0, C_IF,     9);
      add(0, OP_LW,  6'h00, 0, 3'd1, C_NONE,   9);
      add(0, OP_BAD, 6'h3f, 0, 3'd2, C_EX_MEM, 9);
      add(1, OP_BAD, 6'h3f, 0, 3'd3, C_EX_MEM, 9);
      // addu with reset during WB: RegWr suppressed, no retire
      add(0, OP_R, F_ADDU, 0, 3'd0, C_IF,     0);
      add(0, OP_R, F_ADDU, 0, 3'd1, C_NONE,   0);
      add(0, OP_R, F_ADDU, 0, 3'd2, C_EX_ADD, 0);
      add(1, OP_R, F_ADDU, 0, 3'd4, C_EX_ADD, 0);
      add(0, OP_R, F_ADDU, 0, 3'd0, C_IF,     0);
`ifdef MC_MEM_WAIT_EN
      // sw with DMReady low for MEM + 2 WAIT cycles, ready on the third WAIT
      add(0, OP_R,  F_ADDU, 0, 3'd1, C_NONE,   0);
      add(0, OP_R,  F_ADDU, 0, 3'd2, C_EX_ADD, 0);
      add(0, OP_R,  F_ADDU, 0, 3'd4, C_WB_ADD, 0);
      add(0, OP_SW, 6'h00, 0, 3'd0, C_IF,     1);
      add(0, OP_SW, 6'h00, 0, 3'd1, C_NONE,   1);
      add(0, OP_SW, 6'h00, 0, 3'd2, C_EX_MEM, 1);
      add(0, OP_SW, 6'h00, 0, 3'd3, C_MEM_SW, 1, 1'b0);
      add(0, OP_SW, 6'h00, 0, 3'd5, C_MEM_SW, 1, 1'b0);
      add(0, OP_SW, 6'h00, 0, 3'd5, C_MEM_SW, 1, 1'b0);
      add(0, OP_SW, 6'h00, 0, 3'd5, C_MEM_SW, 1, 1'b1);
      // lw with a single WAIT cycle
      add(0, OP_LW, 6'h00, 0, 3'd0, C_IF,     2);
      add(0, OP_LW, 6'h00, 0, 3'd1, C_NONE,   2);
      add(0, OP_LW, 6'h00, 0, 3'd2, C_EX_MEM, 2);
      add(0, OP_LW, 6'h00, 0, 3'd3, C_EX_MEM, 2, 1'b0);
      add(0, OP_LW, 6'h00, 0, 3'd5, C_EX_MEM, 2, 1'b1);
      add(0, OP_LW, 6'h00, 0, 3'd4, C_WB_LW,  2);
      add(0, OP_LW, 6'h00, 0, 3'd0, C_IF,     3);
`endif

      @(posedge clk);
      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         rst = tv[i].rst; opcode = tv[i].op; funct = tv[i].fn;
         zero = tv[i].zero; dmready = tv[i].dmr;
         #1;
         ctl = {pc_wr, ir_wr, npc_sel, reg_wr, reg_dst, ext_op, alu_src,
                mem_wr, mem_to_reg, alu_ctr, illegal};
         check("state", i, 32'(state), 32'(tv[i].st));
         check("ctl",   i, 32'(ctl),   32'(tv[i].ctl));
         check("cnt",   i, instr_cnt,  tv[i].cnt);
         check("cnt_w2", i, 32'(instr_cnt2), 32'(tv[i].cnt % 4));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
